// File: rtl/aes_key_schedule_store.sv
// AES-128/192/256 key expansion engine: expands one word per cycle into an on-chip
// round-key store and serves round keys by index, forward or inverse order.
module aes_key_schedule_store #(
    parameter int MAX_KEY_BITS = 256,
    parameter bit RK_OUT_REG   = 1
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         key_err,
    output logic         busy,
    output logic         keys_valid,
    output logic [3:0]   num_rounds,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    input  logic         rk_rd_inv,
    output logic [127:0] rk_out,
    output logic         rk_rd_err
);
    localparam int MAX_NR = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
    localparam int DEPTH  = 4 * (MAX_NR + 1);
    localparam int IW     = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [2:0]      k_q, k_d;
    logic [3:0]      nk_q, nk_d;
    logic [3:0]      nr_q, nr_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            key_ready_q, key_ready_d;
    logic            busy_q, busy_d;
    logic            keys_valid_q, keys_valid_d;
    logic            key_err_q, key_err_d;
    logic [3:0]      num_rounds_q, num_rounds_d;
    logic [127:0]    rk_out_q, rk_out_d;
    logic            rk_rd_err_q, rk_rd_err_d;

    logic [31:0]     store_q  [DEPTH];
    logic [31:0]     store_d  [DEPTH];
    logic            store_we [DEPTH];

    logic            accept, len_ok;
    logic [3:0]      nk_new, nr_new;
    logic [31:0]     prev_w, far_w, sw_in, sw_out, temp_w, new_w;
    logic [IW-1:0]   last_i;
    logic [3:0]      rd_r;
    logic [5:0]      rd_base;
    logic            rd_ok;
    logic [127:0]    rd_key;

    always_comb begin
        accept = key_valid & key_ready_q;
        case (key_len)
            2'b00:   len_ok = (MAX_KEY_BITS >= 128);
            2'b01:   len_ok = (MAX_KEY_BITS >= 192);
            2'b10:   len_ok = (MAX_KEY_BITS >= 256);
            default: len_ok = 1'b0;
        endcase
        case (key_len)
            2'b00:   begin nk_new = 4'd4; nr_new = 4'd10; end
            2'b01:   begin nk_new = 4'd6; nr_new = 4'd12; end
            default: begin nk_new = 4'd8; nr_new = 4'd14; end
        endcase

        // One S-box bank shared between the RotWord/rcon step and the Nk=8 mid-key step
        prev_w = store_q[i_q - IW'(1)];
        far_w  = store_q[i_q - IW'(nk_q)];
        sw_in  = (k_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sw_out = sub_word(sw_in);
        if (k_q == 3'd0)
            temp_w = sw_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && k_q == 3'd4)
            temp_w = sw_out;
        else
            temp_w = prev_w;
        new_w  = far_w ^ temp_w;
        last_i = IW'({nr_q, 2'b00}) + IW'(4);
    end

    always_comb begin
        rd_r    = rk_rd_inv ? (nr_q - rk_rd_idx) : rk_rd_idx;
        rd_base = {rd_r, 2'b00};
        rd_ok   = keys_valid_q && (rk_rd_idx <= nr_q);
        rd_key  = '0;
        if (rd_ok)
            rd_key = {store_q[rd_base], store_q[rd_base + 6'd1],
                      store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        k_d          = k_q;
        nk_d         = nk_q;
        nr_d         = nr_q;
        rcon_d       = rcon_q;
        key_ready_d  = key_ready_q;
        busy_d       = busy_q;
        keys_valid_d = keys_valid_q;
        key_err_d    = 1'b0;
        num_rounds_d = num_rounds_q;
        for (int j = 0; j < DEPTH; j++) begin
            store_we[j] = 1'b0;
            store_d[j]  = new_w;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && len_ok) begin
                    state_d      = S_EXPAND;
                    nk_d         = nk_new;
                    nr_d         = nr_new;
                    i_d          = IW'(nk_new);
                    k_d          = 3'd0;
                    rcon_d       = 8'h01;
                    key_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    keys_valid_d = 1'b0;
                    num_rounds_d = 4'd0;
                    // w[0] is the most significant word of the right-aligned key
                    for (int j = 0; j < 8; j++) begin
                        if (j < int'(nk_new)) begin
                            store_we[j] = 1'b1;
                            store_d[j]  = key_in[32 * (int'(nk_new) - 1 - j) +: 32];
                        end
                    end
                end else if (accept) begin
                    key_err_d = 1'b1;
                end
            end
            S_EXPAND: begin
                if (i_q == last_i) begin
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    key_ready_d  = 1'b1;
                    keys_valid_d = 1'b1;
                    num_rounds_d = nr_q;
                end else begin
                    for (int j = 0; j < DEPTH; j++)
                        if (IW'(j) == i_q) store_we[j] = 1'b1;
                    i_d = i_q + IW'(1);
                    k_d = ({1'b0, k_q} == nk_q - 4'd1) ? 3'd0 : k_q + 3'd1;
                    if (k_q == 3'd0)
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rk_out_d    = rk_out_q;
        rk_rd_err_d = 1'b0;
        if (rk_rd_en) begin
            rk_out_d    = rd_key;
            rk_rd_err_d = ~rd_ok;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            k_q          <= '0;
            nk_q         <= 4'd4;
            nr_q         <= 4'd10;
            rcon_q       <= 8'h01;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            key_err_q    <= 1'b0;
            num_rounds_q <= 4'd0;
            rk_out_q     <= '0;
            rk_rd_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            k_q          <= k_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            rcon_q       <= rcon_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
            keys_valid_q <= keys_valid_d;
            key_err_q    <= key_err_d;
            num_rounds_q <= num_rounds_d;
            rk_out_q     <= rk_out_d;
            rk_rd_err_q  <= rk_rd_err_d;
        end
    end

    // Store keeps its contents across reset; keys_valid gates every read
    always_ff @(posedge clk_sys) begin
        for (int j = 0; j < DEPTH; j++)
            if (store_we[j]) store_q[j] <= store_d[j];
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign key_err    = key_err_q;
    assign num_rounds = num_rounds_q;

    generate
        if (RK_OUT_REG) begin : g_rd_reg
            assign rk_out    = rk_out_q;
            assign rk_rd_err = rk_rd_err_q;
        end else begin : g_rd_comb
            assign rk_out    = rk_rd_en ? rd_key : '0;
            assign rk_rd_err = rk_rd_en & ~rd_ok;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_schedule_store.sv
// Directed bench for aes_key_schedule_store using FIPS-197 key expansion vectors.
module tb_aes_key_schedule_store;
    logic         clk_sys = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic         key_err;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   num_rounds;
    logic         rk_rd_en = 1'b0;
    logic [3:0]   rk_rd_idx = 4'd0;
    logic         rk_rd_inv = 1'b0;
    logic [127:0] rk_out;
    logic         rk_rd_err;

    int errs = 0;
    int checks = 0;

    localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;

    aes_key_schedule_store dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_len(key_len), .key_in(key_in), .key_err(key_err), .busy(busy),
        .keys_valid(keys_valid), .num_rounds(num_rounds), .rk_rd_en(rk_rd_en),
        .rk_rd_idx(rk_rd_idx), .rk_rd_inv(rk_rd_inv), .rk_out(rk_out), .rk_rd_err(rk_rd_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] idx, input logic inv, input logic [127:0] exp,
                      input logic exp_err, input string tag);
        @(negedge clk_sys);
        rk_rd_en = 1'b1; rk_rd_idx = idx; rk_rd_inv = inv;
        @(posedge clk_sys); #1;
        rk_rd_en = 1'b0;
        chk({tag, "_rk"}, rk_out, exp);
        chk({tag, "_err"}, 128'(rk_rd_err), 128'(exp_err));
    endtask

    // Accept a key, optionally hold key_valid for extra cycles and read on the accept edge,
    // then count edges from the accept until keys_valid rises.
    task automatic load_key(input logic [1:0] len, input logic [255:0] key, input int hold,
                            input int exp_lat, input logic do_rd, input logic [3:0] ridx,
                            input logic [127:0] rexp, input string tag);
        int n;
        @(negedge clk_sys);
        key_len = len; key_in = key; key_valid = 1'b1;
        rk_rd_en = do_rd; rk_rd_idx = ridx; rk_rd_inv = 1'b0;
        @(posedge clk_sys); #1;
        chk({tag, "_ready_lo"}, 128'(key_ready), 128'd0);
        chk({tag, "_busy_hi"}, 128'(busy), 128'd1);
        chk({tag, "_nr_clr"}, 128'(num_rounds), 128'd0);
        if (do_rd) begin
            chk({tag, "_old_rk"}, rk_out, rexp);
            chk({tag, "_old_err"}, 128'(rk_rd_err), 128'd0);
        end
        n = 0;
        while (!keys_valid && n < 200) begin
            if (n >= hold) key_valid = 1'b0;
            @(posedge clk_sys); #1;
            n++;
            if (do_rd && n == 1) begin
                chk({tag, "_busy_rd_err"}, 128'(rk_rd_err), 128'd1);
                chk({tag, "_busy_rd_rk"}, rk_out, 128'd0);
                rk_rd_en = 1'b0;
            end
            if (hold > 0 && n == hold) begin
                chk({tag, "_held_ready"}, 128'(key_ready), 128'd0);
                chk({tag, "_held_err"}, 128'(key_err), 128'd0);
            end
        end
        key_valid = 1'b0; rk_rd_en = 1'b0;
        chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
        chk({tag, "_busy_lo"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_ready", 128'(key_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_kv", 128'(keys_valid), 128'd0);
        chk("rst_nr", 128'(num_rounds), 128'd0);
        chk("rst_rk", rk_out, 128'd0);
        chk("rst_rderr", 128'(rk_rd_err), 128'd0);
        chk("rst_keyerr", 128'(key_err), 128'd0);
        @(negedge clk_sys) rst_n = 1'b1;

        rd(4'd0, 1'b0, 128'd0, 1'b1, "empty_rd");

        load_key(2'b00, {128'h0, K128}, 0, 41, 1'b0, 4'd0, 128'd0, "k128");
        chk("k128_nr", 128'(num_rounds), 128'd10);
        rd(4'd10, 1'b0, R128_10, 1'b0, "k128_r10");
        @(posedge clk_sys); #1;
        chk("k128_hold", rk_out, R128_10);
        rd(4'd0, 1'b1, R128_10, 1'b0, "k128_inv0");
        rd(4'd0, 1'b0, K128, 1'b0, "k128_r0");
        rd(4'd1, 1'b0, R128_1, 1'b0, "k128_r1");
        rd(4'd1, 1'b1, R128_9, 1'b0, "k128_inv1");
        rd(4'd11, 1'b0, 128'd0, 1'b1, "k128_r11");

        // Reserved length in DONE: one-cycle error, schedule untouched
        @(negedge clk_sys);
        key_len = 2'b11; key_valid = 1'b1;
        @(posedge clk_sys); #1;
        key_valid = 1'b0;
        chk("bad_len_err", 128'(key_err), 128'd1);
        chk("bad_len_kv", 128'(keys_valid), 128'd1);
        chk("bad_len_ready", 128'(key_ready), 128'd1);
        chk("bad_len_nr", 128'(num_rounds), 128'd10);
        @(posedge clk_sys); #1;
        chk("bad_len_pulse", 128'(key_err), 128'd0);
        rd(4'd10, 1'b0, R128_10, 1'b0, "bad_len_r10");

        // Re-key in DONE with a same-edge read, key_valid held through part of the expansion
        load_key(2'b01, {64'h0, K192}, 10, 47, 1'b1, 4'd10, R128_10, "k192");
        chk("k192_nr", 128'(num_rounds), 128'd12);
        rd(4'd12, 1'b0, R192_12, 1'b0, "k192_r12");
        rd(4'd12, 1'b1, R192_0, 1'b0, "k192_inv12");
        rd(4'd13, 1'b0, 128'd0, 1'b1, "k192_r13");

        load_key(2'b10, K256, 0, 53, 1'b0, 4'd0, 128'd0, "k256");
        chk("k256_nr", 128'(num_rounds), 128'd14);
        rd(4'd14, 1'b0, R256_14, 1'b0, "k256_r14");
        rd(4'd0, 1'b1, R256_14, 1'b0, "k256_inv0");
        rd(4'd1, 1'b0, R256_1, 1'b0, "k256_r1");
        rd(4'd2, 1'b0, R256_2, 1'b0, "k256_r2");

        // Reset 20 cycles into an AES-256 expansion
        @(negedge clk_sys);
        key_len = 2'b10; key_in = K256; key_valid = 1'b1;
        @(posedge clk_sys); #1;
        key_valid = 1'b0;
        repeat (19) @(posedge clk_sys);
        @(negedge clk_sys) rst_n = 1'b0;
        @(posedge clk_sys); #1;
        chk("midrst_kv", 128'(keys_valid), 128'd0);
        chk("midrst_ready", 128'(key_ready), 128'd1);
        chk("midrst_nr", 128'(num_rounds), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        @(negedge clk_sys) rst_n = 1'b1;
        rd(4'd14, 1'b0, 128'd0, 1'b1, "midrst_rd");

        load_key(2'b00, {128'h0, K128}, 0, 41, 1'b0, 4'd0, 128'd0, "reload128");
        rd(4'd10, 1'b0, R128_10, 1'b0, "reload_r10");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
